// File: rtl/skinny_sbox8_row_sequencer.sv
// Feeds a 32-bit masked row byte by byte through an external masked sbox8 and reassembles the result.
// Optional macro SKINNY_SBOX_PRECHARGE_EN inserts a one-cycle all-zero CLEAR between bytes.
module skinny_sbox8_row_sequencer #(
   parameter int unsigned HOLD_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] row_s0,
   input  logic [31:0] row_s1,
   input  logic [15:0] rnd,
   output logic [7:0]  sbox_si0,
   output logic [7:0]  sbox_si1,
   output logic [15:0] sbox_r,
   input  logic [7:0]  sbox_bo0,
   input  logic [7:0]  sbox_bo1,
   output logic [31:0] out_s0,
   output logic [31:0] out_s1,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
`ifdef SKINNY_SBOX_PRECHARGE_EN
      CLEAR = 2'd2,
`endif
      DONE  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    idx;
   logic [1:0]    nidx;
   logic [CW-1:0] cnt;
   logic [31:0]   row0, row1;
   logic          last_hold;

   assign last_hold = (state == HOLD) && (cnt == CW'(HOLD_CYCLES - 1));
   assign nidx      = idx + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = HOLD;
         HOLD: begin
            if (last_hold) begin
               if (idx == 2'd3) state_nxt = DONE;
`ifdef SKINNY_SBOX_PRECHARGE_EN
               else             state_nxt = CLEAR;
`else
               else             state_nxt = HOLD;
`endif
            end
         end
`ifdef SKINNY_SBOX_PRECHARGE_EN
         CLEAR: state_nxt = HOLD;
`endif
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Share 0 and share 1 travel through disjoint registers and muxes only.
   always_ff @(posedge clk) begin
      if (rst) begin
         row0     <= '0;
         row1     <= '0;
         sbox_si0 <= '0;
         sbox_si1 <= '0;
         sbox_r   <= '0;
         out_s0   <= '0;
         out_s1   <= '0;
         idx      <= '0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  row0     <= row_s0;
                  row1     <= row_s1;
                  sbox_si0 <= row_s0[7:0];
                  sbox_si1 <= row_s1[7:0];
                  sbox_r   <= rnd;
                  idx      <= '0;
                  cnt      <= '0;
               end
            end
            HOLD: begin
               if (last_hold) begin
                  out_s0[{idx, 3'b000} +: 8] <= sbox_bo0;
                  out_s1[{idx, 3'b000} +: 8] <= sbox_bo1;
                  if (idx != 2'd3) begin
                     idx <= nidx;
                     cnt <= '0;
`ifdef SKINNY_SBOX_PRECHARGE_EN
                     sbox_si0 <= '0;
                     sbox_si1 <= '0;
                     sbox_r   <= '0;
`else
                     sbox_si0 <= row0[{nidx, 3'b000} +: 8];
                     sbox_si1 <= row1[{nidx, 3'b000} +: 8];
                     sbox_r   <= rnd;
`endif
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`ifdef SKINNY_SBOX_PRECHARGE_EN
            // idx already points at the byte to load after the precharge cycle.
            CLEAR: begin
               sbox_si0 <= row0[{idx, 3'b000} +: 8];
               sbox_si1 <= row1[{idx, 3'b000} +: 8];
               sbox_r   <= rnd;
               cnt      <= '0;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_skinny_sbox8_row_sequencer.sv
// Directed bench for skinny_sbox8_row_sequencer with a behavioural masked sbox8 attached.
module tb_skinny_sbox8_row_sequencer;

   localparam int HC = 8;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] row_s0, row_s1, out_s0, out_s1;
   logic [15:0] rnd, sbox_r;
   logic [7:0]  sbox_si0, sbox_si1, sbox_bo0, sbox_bo1;
   logic [31:0] o0, o1;
   int          checks = 0;
   int          errors = 0;

   skinny_sbox8_row_sequencer #(.HOLD_CYCLES(HC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .row_s0(row_s0), .row_s1(row_s1), .rnd(rnd),
      .sbox_si0(sbox_si0), .sbox_si1(sbox_si1), .sbox_r(sbox_r),
      .sbox_bo0(sbox_bo0), .sbox_bo1(sbox_bo1),
      .out_s0(out_s0), .out_s1(out_s1), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      rnd = 16'h0000;
      forever begin
         @(posedge clk);
         #1 rnd = 16'($urandom);
      end
   end

   function automatic logic [7:0] s8(input logic [7:0] xin);
      logic [7:0] x;
      x = xin;
      for (int i = 0; i < 4; i++) begin
         x[4] = x[4] ^ ~(x[7] | x[6]);
         x[0] = x[0] ^ ~(x[3] | x[2]);
         if (i < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
         else       x = {x[7:3], x[1], x[2], x[0]};
      end
      return x;
   endfunction

   function automatic logic [31:0] s8row(input logic [31:0] v);
      return {s8(v[31:24]), s8(v[23:16]), s8(v[15:8]), s8(v[7:0])};
   endfunction

   // Masked sbox model: output shares recombine to S8 of the recombined input.
   always_comb begin
      sbox_bo0 = s8(sbox_si0 ^ sbox_si1) ^ sbox_r[7:0];
      sbox_bo1 = sbox_r[7:0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the sequencer idle; returns at the first negedge in DONE.
   task automatic run_row(input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [15:0] er, er_next;
      in_valid = 1'b1;
      row_s0   = a;
      row_s1   = b;
      er       = rnd;
      er_next  = rnd;
      @(negedge clk);
      in_valid = 1'b0;
      row_s0   = 32'hDEADBEEF;
      row_s1   = 32'h0BADF00D;
      chk($sformatf("%s in_ready busy", tag), 32'(in_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < HC; j++) begin
            chk($sformatf("%s si0 b%0d c%0d", tag, i, j), 32'(sbox_si0), 32'(a[8*i +: 8]));
            chk($sformatf("%s si1 b%0d c%0d", tag, i, j), 32'(sbox_si1), 32'(b[8*i +: 8]));
            chk($sformatf("%s r b%0d c%0d", tag, i, j), 32'(sbox_r), 32'(er));
            chk($sformatf("%s out_valid early b%0d c%0d", tag, i, j), 32'(out_valid), 32'd0);
            if (j == HC - 1) er_next = rnd;
            @(negedge clk);
         end
`ifdef SKINNY_SBOX_PRECHARGE_EN
         if (i < 3) begin
            chk($sformatf("%s clear si0 b%0d", tag, i), 32'(sbox_si0), 32'd0);
            chk($sformatf("%s clear si1 b%0d", tag, i), 32'(sbox_si1), 32'd0);
            chk($sformatf("%s clear r b%0d", tag, i), 32'(sbox_r), 32'd0);
            chk($sformatf("%s clear out_valid b%0d", tag, i), 32'(out_valid), 32'd0);
            er_next = rnd;
            @(negedge clk);
         end
`endif
         er = er_next;
      end
      chk($sformatf("%s out_valid", tag), 32'(out_valid), 32'd1);
      chk($sformatf("%s result", tag), out_s0 ^ out_s1, s8row(a ^ b));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      row_s0    = '0;
      row_s1    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst si0", 32'(sbox_si0), 32'd0);
      chk("rst si1", 32'(sbox_si1), 32'd0);
      chk("rst r", 32'(sbox_r), 32'd0);
      chk("rst out_s0", out_s0, 32'd0);
      chk("rst out_s1", out_s1, 32'd0);
      rst = 1'b0;

      run_row(32'hA5A5A5A5, 32'hA5A5A5A5, "zero");
      chk("zero row value", out_s0 ^ out_s1, 32'h65656565);

      // Backpressure in DONE with a competing row offered that must be ignored.
      o0       = out_s0;
      o1       = out_s1;
      in_valid = 1'b1;
      row_s0   = 32'h3C5A96F0;
      row_s1   = 32'h11223344;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("bp out_valid %0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp in_ready %0d", k), 32'(in_ready), 32'd0);
         chk($sformatf("bp out_s0 %0d", k), out_s0, o0);
         chk($sformatf("bp out_s1 %0d", k), out_s1, o1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release in_ready", 32'(in_ready), 32'd1);
      chk("release out_valid", 32'(out_valid), 32'd0);
      run_row(32'h3C5A96F0, 32'h11223344, "rowB");
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("rowB release in_ready", 32'(in_ready), 32'd1);

      // Reset 12 cycles into a row discards it.
      in_valid = 1'b1;
      row_s0   = 32'hCAFEBABE;
      row_s1   = 32'h5EED1234;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst si0", 32'(sbox_si0), 32'd0);
      chk("midrst si1", 32'(sbox_si1), 32'd0);
      chk("midrst r", 32'(sbox_r), 32'd0);
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst out_s0", out_s0, 32'd0);
      run_row(32'hFFFF0000, 32'h12345678, "rowD");
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("rowD release out_valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
